// File: rtl/nibble_serial_add_ctrl_if.sv
// Request/result bundle for the nibble-serial adder: operands in on a
// valid/ready pair, registered result out on a second valid/ready pair.
interface nibble_serial_add_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    // Requester / result consumer side
    modport master (
        output in_valid, a, b, cin, op_sub, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    // Arithmetic sequencer side
    modport slave (
        input  in_valid, a, b, cin, op_sub, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add/subtract built from one 4-bit ripple slice reused once per
// clock, LSB nibble first, with the inter-nibble carry held in a flop.
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    nibble_serial_add_ctrl_if.slave  bus
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
        $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Shared 4-bit ripple slice, fed by the nibble selected by the counter
    logic [3:0] slice_a;
    logic [3:0] slice_b;
    logic [3:0] slice_s;
    logic [4:0] slice_c;

    assign slice_a    = a_q[4*cnt_q +: 4];
    assign slice_b    = b_q[4*cnt_q +: 4];
    assign slice_c[0] = carry_q;

    for (genvar gi = 0; gi < 4; gi++) begin : g_fa
        assign slice_s[gi]   = slice_a[gi] ^ slice_b[gi] ^ slice_c[gi];
        assign slice_c[gi+1] = (slice_a[gi] & slice_b[gi]) |
                               (slice_c[gi] & (slice_a[gi] ^ slice_b[gi]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    // Subtract is A + ~B + 1: invert B here, force carry-in to 1
                    a_d     = bus.a;
                    b_d     = bus.op_sub ? ~bus.b : bus.b;
                    carry_d = bus.op_sub ? 1'b1 : bus.cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[4*cnt_q +: 4] = slice_s;
                carry_d             = slice_c[4];
                if (cnt_q == LAST) begin
                    cout_d  = slice_c[4];
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: directed literal cases plus random traffic
// on a 16-bit instance checked every cycle against an arithmetic model, and an
// 8-bit instance checked for latency and back-to-back throughput.
module tb_nibble_serial_add_ctrl;
    localparam int NIB16 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nibble_serial_add_ctrl_if #(.WIDTH(16)) bus16 ();
    nibble_serial_add_ctrl_if #(.WIDTH(8))  bus8 ();

    nibble_serial_add_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
    nibble_serial_add_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference arithmetic: bit 16 = carry/no-borrow, bits 15:0 = result
    function automatic logic [16:0] ref_calc(input int w, input logic [15:0] a, input logic [15:0] b,
                                             input logic c, input logic s);
        logic [15:0] m;
        logic [16:0] t;
        logic        co;
        m = (w == 16) ? 16'hFFFF : 16'h00FF;
        if (s) begin
            t  = 17'((a & m) - (b & m));
            co = ((a & m) >= (b & m));
        end else begin
            t  = 17'(a & m) + 17'(b & m) + 17'(c);
            co = t[w];
        end
        return {co, t[15:0] & m};
    endfunction

    // Model of the 16-bit instance: an operation is pending from its accept
    // edge; the visible sum gains one nibble per clock until NIB are done.
    int          cyc = 0;
    logic        m_busy;
    int          m_acc;
    logic [15:0] m_res, m_last;
    logic        m_co, m_last_co;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy    <= 1'b0;
            m_acc     <= 0;
            m_res     <= '0;
            m_co      <= 1'b0;
            m_last    <= '0;
            m_last_co <= 1'b0;
        end else if (!m_busy) begin
            if (bus16.in_valid) begin
                m_busy <= 1'b1;
                m_acc  <= cyc;
                {m_co, m_res} <= ref_calc(16, bus16.a, bus16.b, bus16.cin, bus16.op_sub);
            end
        end else if ((cyc - m_acc > NIB16) && bus16.out_ready) begin
            m_busy    <= 1'b0;
            m_last    <= m_res;
            m_last_co <= m_co;
        end
    end

    function automatic logic [15:0] vis_sum(input logic busy, input int steps,
                                            input logic [15:0] res, input logic [15:0] last);
        if (!busy) return last;
        if (steps >= NIB16) return res;
        return res & 16'((32'd1 << (4 * steps)) - 32'd1);
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            check("m_in_ready", bus16.in_ready, !m_busy);
            check("m_busy", bus16.busy, m_busy);
            check("m_out_valid", bus16.out_valid, m_busy && (cyc - m_acc - 1 >= NIB16));
            check("m_sum", bus16.sum, vis_sum(m_busy, cyc - m_acc - 1, m_res, m_last));
            if (!m_busy)
                check("m_cout_idle", bus16.cout, m_last_co);
            else if (cyc - m_acc - 1 >= NIB16)
                check("m_cout_done", bus16.cout, m_co);
        end
    end

    // One 16-bit operation with literal expectations; hold = DONE cycles with
    // out_ready low while in_valid and operands wander.
    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                        input logic [15:0] es, input logic ec, input int hold, input string nm);
        int n;
        bus16.a = a; bus16.b = b; bus16.cin = c; bus16.op_sub = s;
        bus16.in_valid = 1'b1; bus16.out_ready = 1'b0;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        check({nm, "_busy"}, bus16.busy, 1);
        n = 0;
        while (!bus16.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_lat"}, n, NIB16);
        check({nm, "_sum"}, bus16.sum, es);
        check({nm, "_cout"}, bus16.cout, ec);
        for (int k = 0; k < hold; k++) begin
            bus16.in_valid = 1'($urandom_range(0, 1));
            bus16.a = 16'($urandom); bus16.b = 16'($urandom);
            bus16.cin = 1'($urandom_range(0, 1)); bus16.op_sub = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check({nm, "_hold_ov"}, bus16.out_valid, 1);
            check({nm, "_hold_ir"}, bus16.in_ready, 0);
            check({nm, "_hold_sum"}, bus16.sum, es);
            check({nm, "_hold_cout"}, bus16.cout, ec);
        end
        bus16.out_ready = 1'b1;
        if (hold > 0) bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.out_ready = 1'b0;
        bus16.in_valid = 1'b0;
        check({nm, "_hs_ir"}, bus16.in_ready, 1);
        check({nm, "_hs_ov"}, bus16.out_valid, 0);
        check({nm, "_hs_busy"}, bus16.busy, 0);
    endtask

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, last, nres;
        logic [16:0] e;
        logic [16:0] q8[$];

        bus16.in_valid = 0; bus16.a = '0; bus16.b = '0; bus16.cin = 0; bus16.op_sub = 0; bus16.out_ready = 0;
        bus8.in_valid = 0;  bus8.a = '0;  bus8.b = '0;  bus8.cin = 0;  bus8.op_sub = 0;  bus8.out_ready = 0;

        #23 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", bus16.in_ready, 1);
        check("rst_out_valid", bus16.out_valid, 0);
        check("rst_busy", bus16.busy, 0);
        check("rst_sum", bus16.sum, 0);
        check("rst_cout", bus16.cout, 0);

        op16(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 0, "add_basic");
        op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 0, "add_ripple");
        op16(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 0, "add_cin");
        op16(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 0, "sub_pos");
        op16(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 0, "sub_neg");
        op16(16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 5, "backpressure");
        op16(16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1, 0, "after_bp");

        // Asynchronous reset two RUN cycles into an operation
        bus16.a = 16'h1234; bus16.b = 16'h4321; bus16.cin = 1'b1; bus16.op_sub = 1'b0;
        bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_in_ready", bus16.in_ready, 1);
        check("arst_out_valid", bus16.out_valid, 0);
        check("arst_busy", bus16.busy, 0);
        check("arst_sum", bus16.sum, 0);
        check("arst_cout", bus16.cout, 0);
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_rel_ready", bus16.in_ready, 1);
        op16(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 0, "post_rst");

        // Random traffic; the per-cycle model compare does the checking
        for (int i = 0; i < 600; i++) begin
            bus16.in_valid = ($urandom_range(0, 2) != 0);
            bus16.a = pick16(); bus16.b = pick16();
            bus16.cin = 1'($urandom_range(0, 1)); bus16.op_sub = 1'($urandom_range(0, 1));
            bus16.out_ready = ($urandom_range(0, 2) == 0);
            @(posedge clk); #1;
        end
        bus16.in_valid = 1'b0; bus16.out_ready = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        check("rand_drain_idle", bus16.in_ready, 1);
        bus16.out_ready = 1'b0;

        // 8-bit instance: latency of two nibble steps
        bus8.a = 8'hFF; bus8.b = 8'h01; bus8.cin = 1'b1; bus8.op_sub = 1'b0;
        bus8.in_valid = 1'b1; bus8.out_ready = 1'b0;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        n = 0;
        while (!bus8.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("w8_lat", n, 2);
        check("w8_sum", bus8.sum, 8'h01);
        check("w8_cout", bus8.cout, 1);
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        check("w8_hs_ready", bus8.in_ready, 1);

        // Back-to-back with out_ready tied high: one result every 4 cycles
        bus8.in_valid = 1'b1;
        last = -1;
        nres = 0;
        for (int i = 0; i < 40; i++) begin
            bus8.a = 8'($urandom); bus8.b = 8'($urandom);
            bus8.cin = 1'($urandom_range(0, 1)); bus8.op_sub = 1'($urandom_range(0, 1));
            if (bus8.in_ready)
                q8.push_back(ref_calc(8, {8'h00, bus8.a}, {8'h00, bus8.b}, bus8.cin, bus8.op_sub));
            @(posedge clk); #1;
            if (bus8.out_valid) begin
                if (q8.size() == 0) begin
                    check("w8_b2b_unexpected", 1, 0);
                end else begin
                    e = q8.pop_front();
                    check("w8_b2b_sum", bus8.sum, e[7:0]);
                    check("w8_b2b_cout", bus8.cout, e[16]);
                end
                if (last >= 0) check("w8_b2b_period", i - last, 4);
                last = i;
                nres++;
            end
        end
        check("w8_b2b_count", nres, 10);
        bus8.in_valid = 1'b0;
        repeat (4) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer that performs WIDTH-bit add/subtract by time-multiplexing a single 4-bit ripple add slice (the team's adder_4bit), one nibble per clock, LSB nibble first.
- Inter-nibble carry is held in a flop.
- valid/ready on input and output; sits between a requester and its result consumer wherever area matters more than latency.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4, otherwise elaboration error.
- NIB, WIDTH/4 (derived localparam), number of nibble steps per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  requester presents an operation.
- in_ready  output  1  block can accept an operation (IDLE only).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add; ignored when op_sub=1.
- op_sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  registered result.
- cout  output  1  final carry out; for subtract, 1 = no borrow (A>=B unsigned).
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, nibble counter=0, carry flop=0, operand registers=0. Reset mid-operation aborts the operation and discards partial results.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch a, b (b bitwise inverted if op_sub), carry flop = op_sub ? 1 : cin, counter=0, clear sum, go to RUN.
  - Inputs are sampled only at this accept edge; later changes have no effect.
- RUN:
  - in_ready=0.
  - Each edge: slice adds operand nibble[cnt] of A and B plus the carry flop, writes sum[4*cnt+3:4*cnt], and loads the slice carry-out into the carry flop.
  - If cnt==NIB-1: cout = slice carry-out, counter wraps to 0, go to DONE. Otherwise cnt+1.
- DONE:
  - out_valid=1; sum and cout are held stable.
  - On an edge with out_ready=1, go to IDLE. out_valid drops and in_ready rises on that same edge (no same-cycle re-accept).
- Latency: out_valid first high exactly NIB edges after the accept edge (4 for WIDTH=16). Throughput is one operation per NIB+2 cycles with out_ready held high.
- in_valid during RUN/DONE is ignored, not queued.
- out_ready is ignored outside DONE.
- The slice has no internal state; all arithmetic is modulo 2^WIDTH, and overflow shows only through cout.
- Sum nibbles not yet computed read 0 while busy. Consumers must use sum only when out_valid=1.

Test Plan:
1. WIDTH=16, add a=0x1234, b=0x4321, cin=0 -> out_valid exactly 4 cycles after accept, sum=0x5555, cout=0, busy high from accept until the handshake.
2. Add a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, proving carry propagation through all four nibble steps. Also add a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0.
3. Subtract 0x0007-0x0005 -> sum=0x0002, cout=1. Subtract 0x0005-0x0007 -> sum=0xFFFE, cout=0. cin=1 must have no effect in either case.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and the operand inputs -> out_valid, sum and cout stay stable, in_ready=0. Raise out_ready -> IDLE next cycle. A new operation accepted afterwards computes correctly.
5. Assert rst_n low after 2 RUN cycles -> outputs go to reset values immediately without waiting for a clock edge. After release, in_ready=1. A new operation 0x00FF+0x0001 -> 0x0100, cout=0.
6. WIDTH=8 instance: a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1, out_valid 2 cycles after accept. Back-to-back operations with out_ready tied high -> one result every 4 cycles.
